cfu_requant_pack: RTL and testbench
===================================

// Module: cfu_requant_pack
// PURPOSE
//  Downstream of the conv1d CFU datapath: takes int32 accumulators and requantizes each one to int8, TFLite style.
//  Requant chain: fixed-point multiply (SRDHM), rounding right shift, output offset, clamp to the activation range.
//  Packs LANES bytes little-endian into one 32-bit word for rsp_payload / store.
//  Valid/ready on both sides; 3-stage pipeline plus a packer and a 1-entry output register.
// PARAMETERS
//  LANES   4   bytes per output word (fixed 4 for 32-bit out_data)
//  STAT_W  16  width of clamp counter (used only with CFU_REQUANT_STATS_EN)
// PORTS
//  clk            in   1   clock
//  reset          in   1   synchronous, active-high
//  in_valid       in   1   in_acc valid
//  in_ready       out  1   pipeline accepts in_acc this cycle
//  in_acc         in   32  signed int32 accumulator
//  in_last        in   1   with in_valid: flush partial word after this byte
//  cfg_we         in   1   load cfg_* (honoured only when busy=0)
//  cfg_mult       in   32  signed Q31 multiplier
//  cfg_shift      in   5   right shift 0..31
//  cfg_offset     in   16  signed output zero-point
//  cfg_act_min    in   8   signed clamp low
//  cfg_act_max    in   8   signed clamp high (act_min<=act_max required)
//  out_valid      out  1   out_data valid
//  out_ready      in   1   consumer takes word
//  out_data       out  32  packed bytes, byte k = lane k
//  out_bytes      out  3   valid byte count 1..4
//  busy           out  1   any stage valid, packer partial, or out_valid
//  clamp_count    out  STAT_W  saturating count of clamped lanes (macro only)
// BEHAVIOUR
//  Reset: out_valid=0, out_data=0, out_bytes=0, busy=0, all stage valids=0, lane ptr=0.
//   Cfg regs: mult=0x40000000, shift=0, offset=0, min=-128, max=127. Partial data discarded.
//  Stall: adv = !out_valid | out_ready. All stages, packer and input move only when adv=1. in_ready=adv.
//  S1: prod = in_acc*cfg_mult, signed 64b; also flag sat = (acc==mult==INT32_MIN).
//  S2: nudge = prod>=0 ? 2^30 : 1-2^30.
//   srdhm = sat ? 0x7FFFFFFF : (prod+nudge)/2^31, truncating toward zero.
//   rdp: mask=(1<<s)-1; rem=x&mask; thr=(mask>>1)+(x<0); r=(x>>>s)+(rem>thr).
//  S3: v = r + sext(cfg_offset), 33b signed; byte = clamp(v, act_min, act_max)[7:0].
//  Packer: byte goes to lane ptr; ptr++ each byte.
//   Word completes when ptr==LANES-1 or the byte's last=1. in_last travels with the byte.
//   On completion: out_data gets the word, unused lanes zero; out_bytes=count; out_valid=1; ptr=0.
//  Latency: a byte completing a word is accepted at cycle t -> out_valid at t+4 (no stall). Throughput 1 acc/cycle.
//  Output register: holds until out_valid&out_ready. Completing a word while the register drains is allowed (adv=1).
//  cfg_we while busy=1: ignored. cfg_we with in_valid in the same cycle: cfg is loaded first, and the acc uses the new cfg.
//  in_last with ptr==0 gives a 1-byte word. Back-to-back words: no bubble.
//  Reset mid-operation: immediate flush, no word emitted.
// CONFIGURATION
//  CFU_REQUANT_STATS_EN defined:
//   clamp_count increments when v<act_min or v>act_max. Saturates at all-ones. Cleared by reset and by cfg_we.
//  Undefined: clamp_count port and counter absent.
// STRUCTURE
//  Package cfu_requant_pkg:
//   INT32_MIN/INT32_MAX, Q31_HALF=2^30, LANES_DEF=4.
//   typedef struct cfg_t {mult, shift, offset, act_min, act_max}; typedef acc_t (signed 32).
//  Sub-module cfu_rounding_shift: combinational rdp(x,s); instantiated in S2.
// TESTING
//  mult=0x40000000, shift=0, offset=0, range -128..127; acc 10,20,-10,300 -> out_data=0x7FFB0A05, out_bytes=4.
//  mult=INT32_MIN, shift=24, offset=-100; acc=INT32_MIN, in_last=1 -> 0x0000001C, out_bytes=1 (srdhm saturation, rounding up).
//  Rounding: mult=0x40000000, shift=1, acc=3 -> 1; acc=-3 -> -1 (0xFF); check ties.
//  Backpressure: out_ready=0, feed 12 accs -> in_ready drops to 0, no loss.
//   Release out_ready -> 3 words in order, no duplicate.
//  Reset asserted after 2 of 4 bytes -> out_valid stays 0, busy=0. Next 4 accs form a clean word.
//  STATS_EN: range -10..10, acc*0.5 = -50,0,50,5 -> bytes F6,00,0A,05, clamp_count=2. cfg_we -> 0.
//  cfg_we while busy=1 -> cfg unchanged (verify next word).

Source files
------------

// File: rtl/cfu_requant_pkg.sv
// Shared types and constants for the conv1d CFU requantize/pack block.
//
// Contents:
//   INT32_MIN / INT32_MAX : int32 limits, used for the SRDHM saturation case
//   Q31_HALF              : 2^30, the rounding nudge for a Q31 product
//   LANES_DEF             : default number of int8 lanes per 32-bit output word
//   acc_t                 : signed int32 accumulator
//   cfg_t                 : requantization configuration (multiplier, shift,
//                           output offset, activation clamp range)
//   CFG_RESET             : configuration after reset (unity-ish 0.5 multiplier,
//                           no shift, zero offset, full int8 range)
//   srdhm()               : saturating rounding doubling high multiply, taking
//                           the already formed 64-bit product
package cfu_requant_pkg;

  localparam logic [31:0] INT32_MIN = 32'h8000_0000;
  localparam logic [31:0] INT32_MAX = 32'h7FFF_FFFF;
  localparam logic signed [63:0] Q31_HALF = 64'sh0000_0000_4000_0000;
  localparam int LANES_DEF = 4;

  typedef logic signed [31:0] acc_t;

  // Fields are kept as raw bit vectors; users apply $signed where needed.
  typedef struct packed {
    logic [31:0] mult;     // signed Q31 multiplier
    logic [4:0]  shift;    // rounding right shift 0..31
    logic [15:0] offset;   // signed output zero-point
    logic [7:0]  act_min;  // signed clamp low
    logic [7:0]  act_max;  // signed clamp high
  } cfg_t;

  localparam cfg_t CFG_RESET = '{
    mult:    32'h4000_0000,
    shift:   5'd0,
    offset:  16'h0000,
    act_min: 8'h80,
    act_max: 8'h7F
  };

  // (prod + nudge) / 2^31, truncating toward zero. The only product that
  // overflows int32 is INT32_MIN*INT32_MIN, signalled separately by sat.
  function automatic acc_t srdhm(input logic signed [63:0] prod, input logic sat);
    logic signed [63:0] nudged;
    logic               round_up;
    logic [31:0]        quot;
    nudged   = prod + ((prod >= 0) ? Q31_HALF : (64'sd1 - Q31_HALF));
    // Arithmetic shift floors; a negative value with discarded bits must be
    // bumped by one to truncate toward zero instead.
    round_up = nudged[63] && (nudged[30:0] != 31'd0);
    quot     = nudged[62:31] + {31'd0, round_up};
    return sat ? acc_t'(INT32_MAX) : acc_t'(quot);
  endfunction

endpackage

// File: rtl/cfu_requant_pack_rounding_shift.sv
// Combinational rounding divide by power of two (round half away from zero).
//
// Ports:
//   x [31:0] in   signed value to shift
//   s [4:0]  in   shift amount 0..31
//   r [31:0] out  signed rounded result
//
// r = (x >>> s) + (rem > thr), with mask = 2^s-1, rem = x & mask and
// thr = (mask >> 1) + (x < 0). The extra one on the threshold for negative x
// makes an exact half round toward -inf after the floor, i.e. away from zero.
module cfu_rounding_shift (
  input  logic [31:0] x,
  input  logic [4:0]  s,
  output logic [31:0] r
);

  logic [31:0] mask;
  logic [31:0] rem;
  logic [31:0] thr;
  logic [31:0] floor_q;

  assign mask    = (32'd1 << s) - 32'd1;
  assign rem     = x & mask;
  assign thr     = (mask >> 1) + {31'd0, x[31]};
  assign floor_q = $unsigned($signed(x) >>> s);
  assign r       = floor_q + {31'd0, (rem > thr)};

endmodule

// File: rtl/cfu_requant_pack.sv
// Requantize int32 accumulators to int8 (TFLite style) and pack four bytes
// little-endian into a 32-bit word.
//
// Chain: S1 multiply (64b product + INT32_MIN*INT32_MIN flag), S2 SRDHM and
// rounding right shift, S3 offset add and clamp, then a lane packer feeding a
// one-entry output register.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   in_valid/in_ready/in_acc   accumulator input, in_last flushes a partial word
//   cfg_we, cfg_*              configuration load, honoured only while busy=0;
//                              an accumulator accepted in the same cycle already
//                              uses the new configuration
//   out_valid/out_ready        packed word output, out_data byte k = lane k,
//   out_data, out_bytes        out_bytes = number of valid bytes (1..4)
//   busy                       any stage valid, partial word held, or out_valid
//   clamp_count                saturating count of clamped lanes, cleared on
//                              reset and on an honoured cfg_we (only present
//                              when CFU_REQUANT_STATS_EN is defined)
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. The whole pipeline advances together when adv = !out_valid | out_ready;
// in_ready equals adv and does not depend on in_valid.
//
// Build option: define CFU_REQUANT_STATS_EN to add the clamp_count port/counter.
module cfu_requant_pack
  import cfu_requant_pkg::*;
#(
  parameter int LANES = LANES_DEF
`ifdef CFU_REQUANT_STATS_EN
  , parameter int STAT_W = 16
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_acc,
  input  logic        in_last,
  input  logic        cfg_we,
  input  logic [31:0] cfg_mult,
  input  logic [4:0]  cfg_shift,
  input  logic [15:0] cfg_offset,
  input  logic [7:0]  cfg_act_min,
  input  logic [7:0]  cfg_act_max,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [2:0]  out_bytes,
  output logic        busy
`ifdef CFU_REQUANT_STATS_EN
  , output logic [STAT_W-1:0] clamp_count
`endif
);

  localparam int PTR_W = $clog2(LANES);

  // ---------------------------------------------------------------------------
  // Configuration
  // ---------------------------------------------------------------------------
  cfg_t        cfg_q;
  cfg_t        cfg_in;
  logic        cfg_load;
  logic [31:0] mult_eff;
  logic        adv;

  assign cfg_in.mult    = cfg_mult;
  assign cfg_in.shift   = cfg_shift;
  assign cfg_in.offset  = cfg_offset;
  assign cfg_in.act_min = cfg_act_min;
  assign cfg_in.act_max = cfg_act_max;

  assign cfg_load = cfg_we && !busy;

  // Only S1 can see the configuration in the load cycle; later stages read
  // cfg_q, which has been updated by the time the value reaches them.
  assign mult_eff = cfg_load ? cfg_mult : cfg_q.mult;

  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_q <= CFG_RESET;
    end else if (cfg_load) begin
      cfg_q <= cfg_in;
    end
  end

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // ---------------------------------------------------------------------------
  // S1: 32x32 signed multiply
  // ---------------------------------------------------------------------------
  logic               s1_valid;
  logic signed [63:0] s1_prod;
  logic               s1_sat;
  logic               s1_last;
  logic signed [63:0] acc_x;
  logic signed [63:0] mult_x;

  assign acc_x  = {{32{in_acc[31]}}, in_acc};
  assign mult_x = {{32{mult_eff[31]}}, mult_eff};

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_prod  <= '0;
      s1_sat   <= 1'b0;
      s1_last  <= 1'b0;
    end else if (adv) begin
      s1_valid <= in_valid;
      s1_prod  <= acc_x * mult_x;
      s1_sat   <= (in_acc == INT32_MIN) && (mult_eff == INT32_MIN);
      s1_last  <= in_last;
    end
  end

  // ---------------------------------------------------------------------------
  // S2: SRDHM then rounding right shift
  // ---------------------------------------------------------------------------
  logic        s2_valid;
  logic [31:0] s2_r;
  logic        s2_last;
  logic [31:0] srdhm_v;
  logic [31:0] rdp_r;

  assign srdhm_v = srdhm(s1_prod, s1_sat);

  cfu_rounding_shift u_rshift (
    .x (srdhm_v),
    .s (cfg_q.shift),
    .r (rdp_r)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_r     <= '0;
      s2_last  <= 1'b0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      s2_r     <= rdp_r;
      s2_last  <= s1_last;
    end
  end

  // ---------------------------------------------------------------------------
  // S3: output offset and activation clamp
  // ---------------------------------------------------------------------------
  logic               s3_valid;
  logic [7:0]         s3_byte;
  logic               s3_last;
  logic signed [32:0] v;
  logic signed [32:0] v_lo;
  logic signed [32:0] v_hi;
  logic               v_lt_min;
  logic               v_gt_max;
  logic [7:0]         byte_d;

  // 33 bits so that r + offset can never wrap before the clamp.
  assign v    = $signed({s2_r[31], s2_r}) +
                $signed({{17{cfg_q.offset[15]}}, cfg_q.offset});
  assign v_lo = $signed({{25{cfg_q.act_min[7]}}, cfg_q.act_min});
  assign v_hi = $signed({{25{cfg_q.act_max[7]}}, cfg_q.act_max});

  assign v_lt_min = v < v_lo;
  assign v_gt_max = v > v_hi;
  assign byte_d   = v_lt_min ? cfg_q.act_min :
                    v_gt_max ? cfg_q.act_max : v[7:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      s3_valid <= 1'b0;
      s3_byte  <= '0;
      s3_last  <= 1'b0;
    end else if (adv) begin
      s3_valid <= s2_valid;
      s3_byte  <= byte_d;
      s3_last  <= s2_last;
    end
  end

  // ---------------------------------------------------------------------------
  // Packer and output register
  // ---------------------------------------------------------------------------
  logic [PTR_W-1:0] pack_ptr;
  logic [31:0]      pack_buf;   // lanes at and above pack_ptr are always zero
  logic [31:0]      word_next;
  logic             word_done;

  always_comb begin
    word_next = pack_buf;
    for (int k = 0; k < LANES; k++) begin
      if (pack_ptr == PTR_W'(k)) begin
        word_next[8*k +: 8] = s3_byte;
      end
    end
    word_done = (pack_ptr == PTR_W'(LANES - 1)) || s3_last;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pack_ptr  <= '0;
      pack_buf  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_bytes <= '0;
    end else if (adv) begin
      // adv means the output register is empty or being taken this cycle.
      out_valid <= s3_valid && word_done;
      if (s3_valid) begin
        if (word_done) begin
          out_data  <= word_next;
          out_bytes <= 3'(pack_ptr) + 3'd1;
          pack_ptr  <= '0;
          pack_buf  <= '0;
        end else begin
          pack_buf  <= word_next;
          pack_ptr  <= pack_ptr + PTR_W'(1);
        end
      end
    end
  end

  assign busy = s1_valid || s2_valid || s3_valid || (pack_ptr != '0) || out_valid;

`ifdef CFU_REQUANT_STATS_EN
  // ---------------------------------------------------------------------------
  // Clamp statistics: counted as a lane moves from S2 into S3.
  // ---------------------------------------------------------------------------
  logic clamp_hit;

  assign clamp_hit = adv && s2_valid && (v_lt_min || v_gt_max);

  always_ff @(posedge clk) begin
    if (reset || cfg_load) begin
      clamp_count <= '0;
    end else if (clamp_hit && (clamp_count != '1)) begin
      clamp_count <= clamp_count + STAT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_cfu_requant_pack.sv
// Directed bench for cfu_requant_pack: hand-computed words go into an expected
// queue; a monitor pops one entry per output handshake and compares.
module tb_cfu_requant_pack;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_acc;
  logic        in_last;
  logic        cfg_we;
  logic [31:0] cfg_mult;
  logic [4:0]  cfg_shift;
  logic [15:0] cfg_offset;
  logic [7:0]  cfg_act_min;
  logic [7:0]  cfg_act_max;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [2:0]  out_bytes;
  logic        busy;
`ifdef CFU_REQUANT_STATS_EN
  logic [15:0] clamp_count;
`endif

  always #5 clk = ~clk;

  cfu_requant_pack dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_acc      (in_acc),
    .in_last     (in_last),
    .cfg_we      (cfg_we),
    .cfg_mult    (cfg_mult),
    .cfg_shift   (cfg_shift),
    .cfg_offset  (cfg_offset),
    .cfg_act_min (cfg_act_min),
    .cfg_act_max (cfg_act_max),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_bytes   (out_bytes),
    .busy        (busy)
`ifdef CFU_REQUANT_STATS_EN
    , .clamp_count (clamp_count)
`endif
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int          checks = 0;
  int          errors = 0;
  logic [34:0] exp_q[$];   // {out_bytes, out_data}
  logic [34:0] exp_w;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      check("word_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        exp_w = exp_q.pop_front();
        check("out_word", {29'd0, out_bytes, out_data}, {29'd0, exp_w});
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (called just after a rising edge)
  // ---------------------------------------------------------------------------
  task automatic send(input int acc, input logic last);
    bit got;
    int n;
    got      = 1'b0;
    n        = 0;
    in_valid = 1'b1;
    in_acc   = acc;
    in_last  = last;
    while (!got && n < 300) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    cfg_we   = 1'b0;
    check("send_accepted", 64'(got), 64'd1);
  endtask

  task automatic drive_cfg(input int mult, input int shift, input int offset,
                           input int amin, input int amax);
    cfg_mult    = mult;
    cfg_shift   = shift[4:0];
    cfg_offset  = offset[15:0];
    cfg_act_min = amin[7:0];
    cfg_act_max = amax[7:0];
  endtask

  task automatic set_cfg(input int mult, input int shift, input int offset,
                         input int amin, input int amax);
    drive_cfg(mult, shift, offset, amin, amax);
    cfg_we = 1'b1;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    check("drain_idle", 64'(busy), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int  lat;
    bit  saw_stall;

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_acc    = '0;
    in_last   = 1'b0;
    cfg_we    = 1'b0;
    out_ready = 1'b1;
    drive_cfg(0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_bytes", 64'(out_bytes), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Basic word: 0.5 multiplier, clamp of 150 to 127.
    set_cfg(32'h4000_0000, 0, 0, -128, 127);
    exp_q.push_back({3'd4, 32'h7FFB_0A05});
    send(10, 1'b0);
    send(20, 1'b0);
    send(-10, 1'b0);
    send(300, 1'b0);
    drain();

    // SRDHM saturation, shift 24 rounds 127.99 up to 128, offset -100.
    // Configuration is loaded in the same cycle the accumulator is accepted.
    exp_q.push_back({3'd1, 32'h0000_001C});
    drive_cfg(32'h8000_0000, 24, -100, -128, 127);
    cfg_we = 1'b1;
    send(32'h8000_0000, 1'b1);
    lat = 0;
    while (lat < 12) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    check("latency_cycles", 64'(lat), 64'd4);
    @(posedge clk);
    #1;
    drain();

    // Rounding with shift 1: 3->1, -3->-1, ties 6->2 (1.5), -6->-2 (-1.5).
    set_cfg(32'h4000_0000, 1, 0, -128, 127);
    exp_q.push_back({3'd4, 32'hFE02_FF01});
    send(3, 1'b0);
    send(-3, 1'b0);
    send(6, 1'b0);
    send(-6, 1'b0);
    drain();

    // Narrow activation range -10..10: -50,0,50,5 -> F6,00,0A,05.
    set_cfg(32'h4000_0000, 0, 0, -10, 10);
    exp_q.push_back({3'd4, 32'h050A_00F6});
    send(-100, 1'b0);
    send(0, 1'b0);
    send(100, 1'b0);
    send(10, 1'b0);
    drain();
`ifdef CFU_REQUANT_STATS_EN
    check("clamp_count_after", 64'(clamp_count), 64'd2);
    set_cfg(32'h4000_0000, 0, 0, -10, 10);
    check("clamp_count_cleared", 64'(clamp_count), 64'd0);
`endif

    // cfg_we while busy is ignored; a 3-byte word flushed by in_last follows.
    set_cfg(32'h4000_0000, 0, 0, -128, 127);
    exp_q.push_back({3'd4, 32'h0403_0201});
    exp_q.push_back({3'd3, 32'h0003_0201});
    send(2, 1'b0);
    set_cfg(32'h7FFF_FFFF, 3, 50, -1, 1);
    send(4, 1'b0);
    send(6, 1'b0);
    send(8, 1'b1);
    send(2, 1'b0);
    send(4, 1'b0);
    send(6, 1'b1);
    drain();

    // Backpressure: 12 accumulators with the consumer stalled.
    exp_q.push_back({3'd4, 32'h0403_0201});
    exp_q.push_back({3'd4, 32'h0807_0605});
    exp_q.push_back({3'd4, 32'h0C0B_0A09});
    out_ready = 1'b0;
    fork
      begin
        for (int k = 1; k <= 12; k++) send(2 * k, 1'b0);
      end
    join_none
    saw_stall = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (!in_ready) saw_stall = 1'b1;
    end
    check("in_ready_stalled", 64'(saw_stall), 64'd1);
    check("stall_out_valid", 64'(out_valid), 64'd1);
    check("stall_words_held", 64'(exp_q.size()), 64'd3);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait fork;
    drain();

    // Reset after 2 of 4 bytes: nothing is emitted, then a clean word.
    send(2, 1'b0);
    send(4, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    repeat (8) @(posedge clk);
    #1;
    check("midrst_still_idle", 64'(out_valid), 64'd0);
    exp_q.push_back({3'd4, 32'h0403_0201});
    send(2, 1'b0);
    send(4, 1'b0);
    send(6, 1'b0);
    send(8, 1'b0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
